ram_sdp_be: RTL and testbench
=============================

Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port data RAM: one write port, one read port, a single clock.
- Successor to the single-port processor RAM. Adds:
  - per-byte write enables;
  - concurrent read and write;
  - selectable read-during-write behaviour;
  - 1- or 2-cycle read latency with a valid flag;
  - hardware memory clear after reset.
- Sits between the processor memory stage (or DMA/VGA users) and block RAM, replacing per-use initial-block zeroing.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 12, address bus width.
- DEPTH, 4096, number of words; must be ≤ 2^ADDRESS_WIDTH.
- READ_LATENCY, 1, 1 = registered array read; 2 = additional output register.
- RDW_MODE, 0, same-address read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- INIT_VALUE, 0, word written to every location by the post-reset clear sequence.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- init_busy  output  1  high while the clear sequence runs; both ports are ignored while it is high.
- wr_en  input  1  write request.
- wr_addr  input  ADDRESS_WIDTH  write word address.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDRESS_WIDTH  read word address.
- rd_valid  output  1  rd_data carries the result of a read issued READ_LATENCY cycles earlier.
- rd_data  output  DATA_WIDTH  read data; holds its last value when no new read completes.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - rd_valid = 0, rd_data = 0, all pipeline valid bits = 0;
  - FSM goes to CLEAR, clear counter = 0, init_busy = 1.
  - The array itself is not reset.
- FSM states: CLEAR and READY.
  - CLEAR: each cycle writes INIT_VALUE (all bytes) to address clear_cnt, then increments clear_cnt.
  - When clear_cnt = DEPTH-1 is written, next state is READY and init_busy drops to 0 on the following cycle.
  - The clear takes exactly DEPTH cycles after the first clk edge with reset_n = 1.
  - reset_n asserted during CLEAR or READY restarts CLEAR from address 0.
- In CLEAR:
  - wr_en and rd_en are ignored: no array write from the port, no read issued.
  - rd_valid stays 0. Users must wait for init_busy = 0.
- Write (READY, wr_en = 1, wr_addr < DEPTH):
  - at the clock edge, each byte with wr_be[i] = 1 is replaced; other bytes are unchanged.
  - wr_be = 0 means no change.
  - wr_addr ≥ DEPTH: write dropped silently.
- Read (READY, rd_en = 1):
  - READ_LATENCY = 1: rd_data and rd_valid update at the edge following the request edge.
  - READ_LATENCY = 2: one further cycle.
  - rd_addr ≥ DEPTH returns 0 with rd_valid = 1.
  - Back-to-back reads are fully pipelined: one result per cycle.
  - rd_valid = 1 for exactly one cycle per request.
- Read-during-write (same cycle, rd_addr = wr_addr, both enabled):
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged word, with enabled bytes taken from wr_data and the rest from the old word.
- Different-address read and write in the same cycle are independent.
- A read issued the cycle after a write to the same address always returns the written data.
- Non-read cycles: rd_valid = 0 at the corresponding output cycle; rd_data holds.

Decomposition:
- Package ram_pkg holds:
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1;
  - the FSM state encoding (CLEAR, READY);
  - a byte-merge function (old, new, be) → word.
- One sub-module, ram_init_seq: the CLEAR/READY FSM and address counter. Outputs init_busy, clr_we, clr_addr.
- The top level muxes clear writes over port writes.
- The array, byte-lane write and read pipeline stay in the top level so synthesis infers block RAM.

Test Plan:
1. Reset, then release; sample init_busy → init_busy = 1 for exactly DEPTH cycles, then 0. Read addresses 0, 1, DEPTH-1 → each returns INIT_VALUE with rd_valid after READ_LATENCY.
2. Byte enables: write 0xAABBCCDD to addr 5 with be = 4'b1111, then 0x11223344 with be = 4'b0101 → read addr 5 returns 0xAA22CC44.
3. Read-during-write: addr 7 holds 0x0; same cycle write 0xDEADBEEF (be all ones) and read addr 7 → READ_FIRST returns 0x00000000; WRITE_FIRST returns 0xDEADBEEF. Next-cycle read returns 0xDEADBEEF in both modes.
4. Pipelining with READ_LATENCY = 2: reads of addrs 1, 2, 3 on consecutive cycles (preloaded 0x1, 0x2, 0x3) → rd_valid high for 3 consecutive cycles starting 2 cycles after the first request, with data 0x1, 0x2, 0x3. The cycle after that has rd_valid = 0 and rd_data held at 0x3.
5. Port requests during CLEAR: wr_en = 1 to addr 0 with 0xFFFFFFFF and rd_en = 1 while init_busy = 1 → rd_valid never asserts; after the clear, addr 0 reads INIT_VALUE.
6. Reset mid-clear: assert reset_n = 0 at clear_cnt = 100 → rd_valid and rd_data go to 0 immediately and init_busy stays 1. After release, init_busy lasts a full DEPTH cycles again.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable simple-dual-port RAM: read-during-write
// mode codes, clear-sequencer state encoding and the byte-lane merge helper.
package ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // Upper bound on DATA_WIDTH accepted by byte_merge; callers cast in and out.
   localparam int MAX_DATA_WIDTH = 1024;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } init_state_e;

   function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0]   old_word,
      input logic [MAX_DATA_WIDTH-1:0]   new_word,
      input logic [MAX_DATA_WIDTH/8-1:0] be
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_DATA_WIDTH/8; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// Write/read bus of the simple-dual-port RAM; the RAM is the slave, its user
// (processor memory stage, DMA, display engine) is the master.
interface ram_sdp_be_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12
);
   localparam int BYTES = DATA_WIDTH/8;

   logic                     init_busy;
   logic                     wr_en;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [BYTES-1:0]         wr_be;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     rd_en;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     rd_valid;
   logic [DATA_WIDTH-1:0]    rd_data;

   modport master (
      input  init_busy, rd_valid, rd_data,
      output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
   );

   modport slave (
      output init_busy, rd_valid, rd_data,
      input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
   );
endinterface

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: sweeps every address once, one per cycle, then
// hands the array over to the user ports.
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DEPTH         = 4096
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     init_busy,
   output logic                     clr_we,
   output logic [ADDRESS_WIDTH-1:0] clr_addr
);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

   init_state_e              state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_busy = 1'b0;
      clr_we    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            init_busy = 1'b1;
            clr_we    = 1'b1;
            if (cnt_q == LAST_ADDR) state_d = ST_READY;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         ST_READY: ;
         default:  state_d = ST_CLEAR;
      endcase
   end

   assign clr_addr = cnt_q;
endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port block RAM with byte enables, selectable read-during-write
// behaviour, 1/2-cycle read latency and a hardware clear after reset.
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int DEPTH         = 4096,
   parameter int READ_LATENCY  = 1,
   parameter int RDW_MODE      = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic          clk,
   input logic          reset_n,
   ram_sdp_be_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH/8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH+1)'(DEPTH);

   logic                     init_busy, clr_we;
   logic [ADDRESS_WIDTH-1:0] clr_addr;

   ram_init_seq #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DEPTH         (DEPTH)
   ) u_init_seq (
      .clk       (clk),
      .reset_n   (reset_n),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign bus.init_busy = init_busy;

   logic port_wr, port_rd, rd_in_range, same_addr;
   assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;
   assign port_wr     = !init_busy && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT);
   assign port_rd     = !init_busy && bus.rd_en;
   assign same_addr   = bus.wr_addr == bus.rd_addr;

   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [BYTES-1:0]         mem_wbe;

   always_comb begin
      mem_we    = port_wr;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      mem_wbe   = bus.wr_be;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = INIT_VALUE;
         mem_wbe   = '1;
      end
   end

   // Array and its read register carry no reset so they map onto block RAM;
   // the registered read naturally returns the pre-write word on a collision.
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] mem_rd_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (mem_wbe[b]) mem[mem_waddr[IDX_W-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      if (port_rd && rd_in_range) mem_rd_q <= mem[bus.rd_addr[IDX_W-1:0]];
   end

   // Side information captured with each read so the output word can be
   // fixed up (out-of-range zero, write-first forwarding) after the array.
   logic                  rd_v1_q, rd_v1_d;
   logic                  oob1_q, oob1_d;
   logic                  fwd1_q, fwd1_d;
   logic [DATA_WIDTH-1:0] fwd_data1_q, fwd_data1_d;
   logic [BYTES-1:0]      fwd_be1_q, fwd_be1_d;

   always_comb begin
      rd_v1_d     = port_rd;
      oob1_d      = oob1_q;
      fwd1_d      = fwd1_q;
      fwd_data1_d = fwd_data1_q;
      fwd_be1_d   = fwd_be1_q;
      if (port_rd) begin
         oob1_d      = !rd_in_range;
         fwd1_d      = (RDW_MODE == RDW_WRITE_FIRST) && port_wr && same_addr;
         fwd_data1_d = bus.wr_data;
         fwd_be1_d   = bus.wr_be;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_v1_q     <= 1'b0;
         oob1_q      <= 1'b0;
         fwd1_q      <= 1'b0;
         fwd_data1_q <= '0;
         fwd_be1_q   <= '0;
      end else begin
         rd_v1_q     <= rd_v1_d;
         oob1_q      <= oob1_d;
         fwd1_q      <= fwd1_d;
         fwd_data1_q <= fwd_data1_d;
         fwd_be1_q   <= fwd_be1_d;
      end
   end

   logic [DATA_WIDTH-1:0] rd_word1;
   always_comb begin
      rd_word1 = mem_rd_q;
      if (oob1_q) begin
         rd_word1 = '0;
      end else if (fwd1_q) begin
         rd_word1 = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem_rd_q),
                                           MAX_DATA_WIDTH'(fwd_data1_q),
                                           (MAX_DATA_WIDTH/8)'(fwd_be1_q)));
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  rd_v2_q, rd_v2_d;
         logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

         always_comb begin
            rd_v2_d    = rd_v1_q;
            rd_data2_d = rd_v1_q ? rd_word1 : rd_data2_q;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_v2_q    <= 1'b0;
               rd_data2_q <= '0;
            end else begin
               rd_v2_q    <= rd_v2_d;
               rd_data2_q <= rd_data2_d;
            end
         end

         assign bus.rd_valid = rd_v2_q;
         assign bus.rd_data  = rd_data2_q;
      end else begin : g_lat1
         // The un-reset read register is masked until the first read lands.
         logic seen_q, seen_d;
         assign seen_d = seen_q | rd_v1_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) seen_q <= 1'b0;
            else          seen_q <= seen_d;
         end

         assign bus.rd_valid = rd_v1_q;
         assign bus.rd_data  = (seen_q | rd_v1_q) ? rd_word1 : '0;
      end
   endgenerate
endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: a latency-1/read-first RAM and a latency-2/write-first RAM
// driven with identical stimulus and checked against hand-computed values.
module tb_ram_sdp_be;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 256;
   localparam int BW    = DW/8;
   localparam logic [DW-1:0] INIT = 32'h5A5A_0F0F;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en, rd_en;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [BW-1:0] wr_be;
   logic [DW-1:0] wr_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_sdp_be_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_a ();
   ram_sdp_be_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_b ();

   assign bus_a.wr_en = wr_en;     assign bus_b.wr_en = wr_en;
   assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
   assign bus_a.wr_be = wr_be;     assign bus_b.wr_be = wr_be;
   assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
   assign bus_a.rd_en = rd_en;     assign bus_b.rd_en = rd_en;
   assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr;

   ram_sdp_be #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
                .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT))
      dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

   ram_sdp_be #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
                .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(INIT))
      dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [BW-1:0] be;
      logic          re;
      logic [AW-1:0] ra;
      logic [DW-1:0] ea;   // expected from the read-first, latency-1 RAM
      logic [DW-1:0] eb;   // expected from the write-first, latency-2 RAM
      string         name;
   } vec_t;

   function automatic vec_t mk(logic we, int wa, logic [DW-1:0] wd, logic [BW-1:0] be,
                               logic re, int ra, logic [DW-1:0] ea, logic [DW-1:0] eb,
                               string name);
      vec_t v;
      v.we = we; v.wa = AW'(wa); v.wd = wd; v.be = be;
      v.re = re; v.ra = AW'(ra); v.ea = ea; v.eb = eb; v.name = name;
      return v;
   endfunction

   // One cycle of port activity, released at the following falling edge.
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic re, input logic [AW-1:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
      $display("xact t=%0t we=%0b wa=%0d wd=%h be=%b re=%0b ra=%0d", $time, we, wa, wd, be, re, ra);
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // Snapshots {valid,data} of both RAMs one and two cycles after a read.
   task automatic sample2(output logic [DW:0] a1, output logic [DW:0] b1,
                          output logic [DW:0] a2, output logic [DW:0] b2);
      a1 = {bus_a.rd_valid, bus_a.rd_data}; b1 = {bus_b.rd_valid, bus_b.rd_data};
      @(negedge clk);
      a2 = {bus_a.rd_valid, bus_a.rd_data}; b2 = {bus_b.rd_valid, bus_b.rd_data};
   endtask

   task automatic count_busy(output int na, output int nb);
      na = 0; nb = 0;
      for (int c = 0; c < 4*DEPTH && (bus_a.init_busy || bus_b.init_busy); c++) begin
         if (bus_a.init_busy) na++;
         if (bus_b.init_busy) nb++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int na, nb;
      reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL reset_a: got busy=%0b valid=%0b data=%h expected 1 0 0",
                            bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data);
      end
      checks++;
      if ({bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL reset_b: got busy=%0b valid=%0b data=%h expected 1 0 0",
                            bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data);
      end
      reset_n = 1'b1;
      count_busy(na, nb);
      checks++;
      if (na != DEPTH) begin errors++; $display("FAIL clear_len_a: got %0d expected %0d", na, DEPTH); end
      checks++;
      if (nb != DEPTH) begin errors++; $display("FAIL clear_len_b: got %0d expected %0d", nb, DEPTH); end
   endtask

   task automatic test_init_values;
      vec_t v[$];
      logic [DW:0] a1, b1, a2, b2;
      v.push_back(mk(0, 0, 0, 0, 1, 0,       INIT, INIT, "init_addr0"));
      v.push_back(mk(0, 0, 0, 0, 1, 1,       INIT, INIT, "init_addr1"));
      v.push_back(mk(0, 0, 0, 0, 1, DEPTH-1, INIT, INIT, "init_last"));
      foreach (v[i]) begin
         drive(v[i].we, v[i].wa, v[i].wd, v[i].be, v[i].re, v[i].ra);
         sample2(a1, b1, a2, b2);
         checks++; if (a1 !== {1'b1, v[i].ea}) begin errors++; $display("FAIL %s_lat1: got v=%0b d=%h expected v=1 d=%h", v[i].name, a1[DW], a1[DW-1:0], v[i].ea); end
         checks++; if (b1[DW] !== 1'b0) begin errors++; $display("FAIL %s_lat2_early: got valid=%0b expected 0", v[i].name, b1[DW]); end
         checks++; if (b2 !== {1'b1, v[i].eb}) begin errors++; $display("FAIL %s_lat2: got v=%0b d=%h expected v=1 d=%h", v[i].name, b2[DW], b2[DW-1:0], v[i].eb); end
         checks++; if (a2 !== {1'b0, v[i].ea}) begin errors++; $display("FAIL %s_lat1_hold: got v=%0b d=%h expected v=0 d=%h", v[i].name, a2[DW], a2[DW-1:0], v[i].ea); end
      end
   endtask

   task automatic test_byte_enables;
      vec_t v[$];
      logic [DW:0] a1, b1, a2, b2;
      v.push_back(mk(1, 5,       32'hAABBCCDD, 4'b1111, 0, 0, 0, 0, "be_full"));
      v.push_back(mk(1, 5,       32'h11223344, 4'b0101, 0, 0, 0, 0, "be_partial"));
      v.push_back(mk(1, 5,       32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, "be_none"));
      v.push_back(mk(1, DEPTH+5, 32'h00000000, 4'b1111, 0, 0, 0, 0, "wr_oob"));
      v.push_back(mk(0, 0, 0, 0, 1, 5,   32'hAA22CC44, 32'hAA22CC44, "be_merge"));
      v.push_back(mk(0, 0, 0, 0, 1, 300, 32'h00000000, 32'h00000000, "rd_oob"));
      foreach (v[i]) begin
         drive(v[i].we, v[i].wa, v[i].wd, v[i].be, v[i].re, v[i].ra);
         if (v[i].re) begin
            sample2(a1, b1, a2, b2);
            checks++; if (a1 !== {1'b1, v[i].ea}) begin errors++; $display("FAIL %s_lat1: got v=%0b d=%h expected v=1 d=%h", v[i].name, a1[DW], a1[DW-1:0], v[i].ea); end
            checks++; if (b1[DW] !== 1'b0) begin errors++; $display("FAIL %s_lat2_early: got valid=%0b expected 0", v[i].name, b1[DW]); end
            checks++; if (b2 !== {1'b1, v[i].eb}) begin errors++; $display("FAIL %s_lat2: got v=%0b d=%h expected v=1 d=%h", v[i].name, b2[DW], b2[DW-1:0], v[i].eb); end
            checks++; if (a2 !== {1'b0, v[i].ea}) begin errors++; $display("FAIL %s_lat1_hold: got v=%0b d=%h expected v=0 d=%h", v[i].name, a2[DW], a2[DW-1:0], v[i].ea); end
         end
      end
   endtask

   task automatic test_read_during_write;
      vec_t v[$];
      logic [DW:0] a1, b1, a2, b2;
      v.push_back(mk(1, 7, 32'h00000000, 4'b1111, 0, 0, 0, 0, "rdw_zero"));
      v.push_back(mk(1, 7, 32'hDEADBEEF, 4'b1111, 1, 7, 32'h00000000, 32'hDEADBEEF, "rdw_full"));
      v.push_back(mk(0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, "rdw_after"));
      v.push_back(mk(1, 7, 32'h11223344, 4'b0011, 1, 7, 32'hDEADBEEF, 32'hDEAD3344, "rdw_partial"));
      v.push_back(mk(1, 8, 32'hCAFEF00D, 4'b1111, 0, 0, 0, 0, "wr_8"));
      v.push_back(mk(0, 0, 0, 0, 1, 8, 32'hCAFEF00D, 32'hCAFEF00D, "rd_next_cycle"));
      v.push_back(mk(1, 9, 32'h12345678, 4'b1111, 1, 8, 32'hCAFEF00D, 32'hCAFEF00D, "diff_addr"));
      v.push_back(mk(0, 0, 0, 0, 1, 9, 32'h12345678, 32'h12345678, "rd_9"));
      v.push_back(mk(0, 0, 0, 0, 1, 7, 32'hDEAD3344, 32'hDEAD3344, "rd_7_final"));
      foreach (v[i]) begin
         drive(v[i].we, v[i].wa, v[i].wd, v[i].be, v[i].re, v[i].ra);
         if (v[i].re) begin
            sample2(a1, b1, a2, b2);
            checks++; if (a1 !== {1'b1, v[i].ea}) begin errors++; $display("FAIL %s_lat1: got v=%0b d=%h expected v=1 d=%h", v[i].name, a1[DW], a1[DW-1:0], v[i].ea); end
            checks++; if (b2 !== {1'b1, v[i].eb}) begin errors++; $display("FAIL %s_lat2: got v=%0b d=%h expected v=1 d=%h", v[i].name, b2[DW], b2[DW-1:0], v[i].eb); end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic ea_v[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int   ea_d[5] = '{1, 2, 3, 3, 3};
      logic eb_v[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int   eb_d[5] = '{0, 1, 2, 3, 3};
      for (int i = 1; i <= 3; i++) drive(1'b1, AW'(i), DW'(i), 4'b1111, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         rd_en   = (i < 3);
         rd_addr = AW'(i + 1);
         $display("xact t=%0t pipelined re=%0b ra=%0d", $time, rd_en, rd_addr);
         @(negedge clk);
         checks++;
         if ({bus_a.rd_valid, bus_a.rd_data} !== {ea_v[i], DW'(ea_d[i])}) begin
            errors++; $display("FAIL b2b_lat1_%0d: got v=%0b d=%h expected v=%0b d=%h",
                               i, bus_a.rd_valid, bus_a.rd_data, ea_v[i], ea_d[i]);
         end
         checks++;
         if (bus_b.rd_valid !== eb_v[i]) begin
            errors++; $display("FAIL b2b_lat2_valid_%0d: got %0b expected %0b", i, bus_b.rd_valid, eb_v[i]);
         end
         if (i >= 1) begin
            checks++;
            if (bus_b.rd_data !== DW'(eb_d[i])) begin
               errors++; $display("FAIL b2b_lat2_data_%0d: got %h expected %h", i, bus_b.rd_data, eb_d[i]);
            end
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_clear_ignores_ports;
      int  n;
      logic saw_valid;
      logic [DW:0] a1, b1, a2, b2;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL async_reset_a: got busy=%0b valid=%0b data=%h expected 1 0 0",
                            bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data);
      end
      checks++;
      if ({bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL async_reset_b: got busy=%0b valid=%0b data=%h expected 1 0 0",
                            bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data);
      end
      @(negedge clk);
      wr_en = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF; wr_be = '1;
      rd_en = 1'b1; rd_addr = '0;
      reset_n = 1'b1;
      $display("xact t=%0t requests held during clear", $time);
      n = 0; saw_valid = 1'b0;
      while ((bus_a.init_busy || bus_b.init_busy) && n < 4*DEPTH) begin
         @(negedge clk);
         n++;
         if (bus_a.rd_valid || bus_b.rd_valid) saw_valid = 1'b1;
      end
      wr_en = 1'b0; rd_en = 1'b0;
      checks++;
      if (saw_valid !== 1'b0) begin errors++; $display("FAIL clear_rd_valid: got 1 expected 0"); end
      checks++;
      if (n != DEPTH) begin errors++; $display("FAIL clear_len_ports: got %0d expected %0d", n, DEPTH); end
      drive(1'b0, '0, '0, '0, 1'b1, '0);
      sample2(a1, b1, a2, b2);
      checks++; if (a1 !== {1'b1, INIT}) begin errors++; $display("FAIL clear_addr0_lat1: got v=%0b d=%h expected v=1 d=%h", a1[DW], a1[DW-1:0], INIT); end
      checks++; if (b2 !== {1'b1, INIT}) begin errors++; $display("FAIL clear_addr0_lat2: got v=%0b d=%h expected v=1 d=%h", b2[DW], b2[DW-1:0], INIT); end
   endtask

   task automatic test_reset_mid_clear;
      int na, nb;
      logic [DW:0] a1, b1, a2, b2;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if ({bus_a.init_busy, bus_b.init_busy} !== 2'b11) begin
         errors++; $display("FAIL mid_clear_busy: got %b expected 11", {bus_a.init_busy, bus_b.init_busy});
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data, bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data}
          !== {2'b10, 32'h0, 2'b10, 32'h0}) begin
         errors++; $display("FAIL mid_clear_reset: got a=%0b%0b/%h b=%0b%0b/%h expected 10/0 10/0",
                            bus_a.init_busy, bus_a.rd_valid, bus_a.rd_data,
                            bus_b.init_busy, bus_b.rd_valid, bus_b.rd_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      count_busy(na, nb);
      checks++;
      if (na != DEPTH) begin errors++; $display("FAIL reclear_len_a: got %0d expected %0d", na, DEPTH); end
      checks++;
      if (nb != DEPTH) begin errors++; $display("FAIL reclear_len_b: got %0d expected %0d", nb, DEPTH); end
      drive(1'b0, '0, '0, '0, 1'b1, AW'(5));
      sample2(a1, b1, a2, b2);
      checks++; if (a1 !== {1'b1, INIT}) begin errors++; $display("FAIL reclear_addr5_lat1: got v=%0b d=%h expected v=1 d=%h", a1[DW], a1[DW-1:0], INIT); end
      checks++; if (b2 !== {1'b1, INIT}) begin errors++; $display("FAIL reclear_addr5_lat2: got v=%0b d=%h expected v=1 d=%h", b2[DW], b2[DW-1:0], INIT); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_values();
      test_byte_enables();
      test_read_during_write();
      test_back_to_back();
      test_clear_ignores_ports();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
